// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer
//   Rate-1/2, K=3 convolutional encoder (g0 = 111, g1 = 101) with frame
//   termination. It emits one 2-bit symbol per accepted data bit. At each
//   frame end it appends two zero-tail symbols, so the trellis returns to
//   state 00 at every frame boundary.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   in_bit     : serial data bit
//   in_valid   : in_bit is valid
//   in_last    : accepted bit is the last bit of a short frame
//   in_ready   : block takes in_bit this cycle
//   sym        : coded symbol {c0, c1}
//   sym_valid  : sym is valid
//   sym_last   : sym is the second (final) tail symbol of a frame
//   sym_ready  : sink takes sym this cycle
//   busy       : current frame not yet fully emitted
module conv_encoder_framer #(
  parameter int FRAME_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] sym,
  output logic       sym_valid,
  output logic       sym_last,
  input  logic       sym_ready,
  output logic       busy
);

  localparam logic [0:0] ST_DATA = 1'b0;
  localparam logic [0:0] ST_TAIL = 1'b1;

  logic [0:0]       state;
  logic [1:0]       enc_s;    // {s1, s0}: previous input bit, bit before it
  logic [CNT_W-1:0] cnt;      // data bits accepted in the current frame
  logic             tcnt;     // tail symbols already emitted

  logic can_load;
  logic accept;
  logic tail_load;
  logic load;
  logic d;
  logic frame_end;

  // The output register may take a new symbol when it is empty or draining.
  assign can_load  = !sym_valid | sym_ready;
  // Gating with reset keeps in_ready low for the whole time reset is held,
  // even though the FSM already sits in DATA with an empty output register.
  assign in_ready  = reset & (state == ST_DATA) & can_load;
  assign accept    = in_valid & in_ready;
  assign tail_load = (state == ST_TAIL) & can_load;
  assign load      = accept | tail_load;
  // Tail symbols encode d = 0, which flushes the shift register to 00.
  assign d         = accept & in_bit;
  // The FRAME_LEN-th bit ends the frame whether or not in_last is set, so
  // in_last on that bit cannot produce a second tail.
  assign frame_end = in_last | (cnt == CNT_W'(FRAME_LEN - 1));
  assign busy      = (state == ST_TAIL) | sym_valid | (cnt != '0);

  // Frame control: data-bit count, tail count, DATA/TAIL state.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_DATA;
      cnt   <= '0;
      tcnt  <= 1'b0;
    end else begin
      if (accept) begin
        if (frame_end) begin
          state <= ST_TAIL;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (tail_load) begin
        if (tcnt) begin
          state <= ST_DATA;
          cnt   <= '0;
          tcnt  <= 1'b0;
        end else begin
          tcnt  <= 1'b1;
        end
      end
    end
  end

  // Encoder shift register and output register. Both advance only on a load,
  // so a stall freezes the trellis state with the symbol that is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_s     <= 2'b00;
      sym       <= 2'b00;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
    end else if (load) begin
      sym       <= {d ^ enc_s[1] ^ enc_s[0], d ^ enc_s[0]};
      sym_valid <= 1'b1;
      sym_last  <= tail_load & tcnt;
      enc_s     <= {d, enc_s[1]};
    end else if (sym_ready) begin
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb_conv_encoder_framer
//   Self-checking bench for conv_encoder_framer. A reference model turns each
//   accepted frame into symbols with the generator polynomials:
//     c0 = b[i] ^ b[i-1] ^ b[i-2]
//     c1 = b[i] ^ b[i-2]
//   Bits before the frame start and the two tail positions count as zero.
//   One compare process checks every output handshake against the model and
//   checks that a stalled symbol stays unchanged. Literal symbol lists pin
//   both the model stream and the observed DUT stream for each directed case.
module tb_conv_encoder_framer;

  localparam int FRAME_LEN = 32;
  localparam int CNT_W     = 6;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       in_bit    = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_last   = 1'b0;
  logic       sym_ready = 1'b1;
  logic       in_ready;
  logic [1:0] sym;
  logic       sym_valid;
  logic       sym_last;
  logic       busy;

  int tests       = 0;
  int fails       = 0;
  int rdy_mode    = 0;
  int rdy_idx     = 0;
  int nready_cnt  = 0;

  bit         fbits[$];           // bits of the frame being sent
  logic [2:0] expq[$];            // pending expected {last, c0, c1}
  logic [2:0] mlog[$];            // everything the model produced
  logic [2:0] dlog[$];            // everything the DUT handed over
  logic       prev_stall = 1'b0;
  logic [2:0] prev_out   = 3'b000;
  logic [2:0] exp_e;

  always #5 clk = ~clk;

  conv_encoder_framer #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sym       (sym),
    .sym_valid (sym_valid),
    .sym_last  (sym_last),
    .sym_ready (sym_ready),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_seq(input string name, input logic [2:0] got[$], input logic [2:0] exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) check(name, got[i], exp[i]);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit fb(int i);
    return (i >= 0 && i < fbits.size()) ? fbits[i] : 1'b0;
  endfunction

  function automatic logic [1:0] model_sym(int i);
    bit b0 = fb(i);
    bit b1 = fb(i - 1);
    bit b2 = fb(i - 2);
    return {b0 ^ b1 ^ b2, b0 ^ b2};
  endfunction

  task automatic model_push(input logic [2:0] e);
    expq.push_back(e);
    mlog.push_back(e);
  endtask

  task automatic model_accept(input bit b, input bit last);
    int n;
    fbits.push_back(b);
    n = fbits.size();
    model_push({1'b0, model_sym(n - 1)});
    if (last || n == FRAME_LEN) begin
      model_push({1'b0, model_sym(n)});
      model_push({1'b1, model_sym(n + 1)});
      fbits.delete();
    end
  endtask

  // ---------------- sink readiness ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      sym_ready = 1'b1;
    end else begin
      sym_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
      rdy_idx++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_sym", {sym_valid, sym_last, sym}, {1'b1, prev_out});
      if (!in_ready) nready_cnt++;
      if (sym_valid && !sym_ready) check("in_ready_stalled", in_ready, 0);
      if (sym_valid && sym_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_sym", 1, 0);
        end else begin
          exp_e = expq.pop_front();
          check("sym", {sym_last, sym}, exp_e);
          dlog.push_back({sym_last, sym});
        end
      end
      prev_stall = sym_valid & !sym_ready;
      prev_out   = {sym_last, sym};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_frame(input bit bits[$], input bit use_last);
    foreach (bits[k]) begin
      bit done;
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_bit   = bits[k];
        in_last  = use_last && (k == bits.size() - 1);
        @(negedge clk);
        if (in_ready) begin
          model_accept(bits[k], in_last);
          done = 1'b1;
        end
      end
      if (!done) check("accept_timeout", 0, 1);
    end
  endtask

  task automatic drop();
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((expq.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, (expq.size() != 0 || busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [2:0] lit[$];
    logic [2:0] lit_full[$];
    bit         bits[$];
    bit         ones[$];
    int         t;

    // Reset state while reset is held
    #12;
    check("rst_in_ready",  in_ready,  0);
    check("rst_sym",       sym,       0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_last",  sym_last,  0);
    check("rst_busy",      busy,      0);
    reset = 1'b1;

    // Idle: nothing offered for 10 cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_sym_valid", sym_valid, 0);
      check("idle_in_ready",  in_ready,  1);
      check("idle_busy",      busy,      0);
    end

    // Short frame 1,0,1,1 with in_last on the 4th bit
    mlog.delete(); dlog.delete();
    bits = '{1, 0, 1, 1};
    send_frame(bits, 1'b1);
    drop();
    t = 0;
    while (!(sym_valid && sym_last) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("short_last_seen", sym_valid && sym_last, 1);
    @(negedge clk);
    check("short_busy_after", busy, 0);
    lit = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    check_seq("short_model", mlog, lit);
    check_seq("short_dut",   dlog, lit);

    // Full frame: 32 ones, no in_last
    ones.delete();
    for (int i = 0; i < FRAME_LEN; i++) ones.push_back(1'b1);
    lit_full = '{3'b011, 3'b001};
    for (int i = 0; i < FRAME_LEN - 2; i++) lit_full.push_back(3'b010);
    lit_full.push_back(3'b001);
    lit_full.push_back(3'b111);
    mlog.delete(); dlog.delete();
    nready_cnt = 0;
    send_frame(ones, 1'b0);
    drop();
    wait_drain("full_drain");
    check("full_tail_ready_low", nready_cnt, 2);
    check_seq("full_model", mlog, lit_full);
    check_seq("full_dut",   dlog, lit_full);

    // Full frame with in_last on the 32nd bit: still one tail only
    mlog.delete(); dlog.delete();
    send_frame(ones, 1'b1);
    drop();
    wait_drain("full_last_drain");
    check_seq("full_last_dut", dlog, lit_full);

    // Backpressure: sym_ready pattern 1,0,0,1,...
    mlog.delete(); dlog.delete();
    rdy_idx  = 0;
    rdy_mode = 1;
    bits = '{1, 0, 1, 1};
    send_frame(bits, 1'b1);
    drop();
    wait_drain("bp_drain");
    rdy_mode = 0;
    check_seq("bp_dut", dlog, lit);

    // Back-to-back frames {1,0} twice with in_valid held high
    mlog.delete(); dlog.delete();
    bits = '{1, 0};
    send_frame(bits, 1'b1);
    send_frame(bits, 1'b1);
    drop();
    wait_drain("b2b_drain");
    lit = '{3'b011, 3'b010, 3'b011, 3'b100, 3'b011, 3'b010, 3'b011, 3'b100};
    check_seq("b2b_model", mlog, lit);
    check_seq("b2b_dut",   dlog, lit);

    // Reset after the 2nd symbol of a 32-bit frame
    mlog.delete(); dlog.delete();
    bits = '{1, 1};
    send_frame(bits, 1'b0);
    drop();
    t = 0;
    while (dlog.size() < 2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #2 reset = 1'b0;
    #1;
    check("rstmid_sym_valid", sym_valid, 0);
    check("rstmid_sym_last",  sym_last,  0);
    check("rstmid_busy",      busy,      0);
    check("rstmid_in_ready",  in_ready,  0);
    expq.delete();
    fbits.delete();
    lit = '{3'b011, 3'b001};
    check_seq("rstmid_prefix", dlog, lit);
    @(negedge clk); #2;
    reset = 1'b1;
    mlog.delete(); dlog.delete();
    bits = '{1, 1};
    send_frame(bits, 1'b1);
    drop();
    wait_drain("rstmid_drain");
    lit = '{3'b011, 3'b001, 3'b001, 3'b111};
    check_seq("rstmid_model", mlog, lit);
    check_seq("rstmid_dut",   dlog, lit);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_encoder_framer.md
# conv_encoder_framer

Rate-1/2, constraint-length-3 convolutional encoder with frame termination. It is the transmit-side counterpart of the 4-state Viterbi decoder. The block accepts a serial data-bit stream over a valid/ready handshake and emits one 2-bit coded symbol per accepted bit. At each frame end it appends two zero-tail symbols so the trellis returns to state 0, which is what the decoder expects at a frame boundary.

## Interface
Parameters:
- FRAME_LEN, 32: maximum data bits per frame. Must be ≥ 1 and ≤ 2^CNT_W − 1.
- CNT_W, 6: width of the data-bit counter.

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; clock clk
- in_bit  input  1  data bit
- in_valid  input  1  in_bit is valid
- in_last  input  1  qualifies in_bit as the last bit of a short frame
- in_ready  output  1  block accepts in_bit this cycle
- sym  output  2  coded symbol {c0, c1}
- sym_valid  output  1  sym is valid
- sym_last  output  1  sym is the final tail symbol of a frame
- sym_ready  input  1  sink accepts sym this cycle
- busy  output  1  high whenever the current frame is not yet fully emitted

## Operation
- Encoder state s = {s1, s0}: s1 is the previous input bit, s0 the bit before it.
- Generators are g0 = 111 and g1 = 101:
  - c0 = d ^ s1 ^ s0
  - c1 = d ^ s0
  - next s = {d, s1}
- FSM states:
  - DATA:
    - in_ready = can_load, where can_load = !sym_valid | sym_ready.
    - On accept (in_valid & in_ready): encode d = in_bit, load the output register, cnt ← cnt + 1.
    - Go to TAIL when the accepted bit has in_last = 1 or cnt = FRAME_LEN − 1. Otherwise stay in DATA.
  - TAIL:
    - in_ready = 0.
    - Each cycle with can_load, encode d = 0 and load the output register; tcnt ← tcnt + 1.
    - On the second tail symbol, set sym_last = 1 with it, go to DATA, clear cnt and tcnt, and s becomes 00 as a natural consequence of the tail.
- Output register (sym, sym_valid, sym_last):
  - Loaded only when can_load.
  - Held stable while sym_valid & !sym_ready.
  - sym_valid clears when the register drains (sym_ready high) and no new load occurs.
- busy = (FSM == TAIL) | sym_valid | (cnt ≠ 0).
- in_last on a cycle with no handshake is ignored.
- in_last on the FRAME_LEN-th bit terminates the frame once; it does not produce an extra tail.
- Frames are back-to-back: DATA can accept the first bit of the next frame in the same cycle the last tail symbol drains.

## Timing
- Reset values:
  - in_ready = 0 while reset is asserted, then in_ready = 1 in the first DATA cycle
  - sym = 00
  - sym_valid = 0
  - sym_last = 0
  - busy = 0
  - s = 00
  - cnt = 0
  - tcnt = 0
  - FSM = DATA
- Latency: an accepted bit at edge N produces sym_valid at edge N, visible in cycle N+1. Latency is 1 cycle.
- Throughput: with sym_ready held high, 1 symbol per cycle. A frame of L bits occupies L + 2 output cycles.
- in_ready is combinational from sym_valid, sym_ready and FSM state. It has no combinational path from in_valid.
- Backpressure:
  - With sym_ready = 0 and sym_valid = 1: in_ready = 0, TAIL stalls, and the encoder state and counters are frozen.
- Reset asserted mid-frame: all registers clear immediately. A partially emitted frame is discarded with no tail and no sym_last.
- Counter wrap: cnt never exceeds FRAME_LEN − 1. The FRAME_LEN-th bit forces TAIL.

## Test plan
- Short frame: bits 1, 0, 1, 1 with in_last on the 4th bit, sym_ready = 1.
  - Expect sym 11, 10, 00, 01, 01, 11 on consecutive cycles.
  - sym_last only on the final 11.
  - busy drops the cycle after it.
- Full frame: 32 ones, in_last never asserted.
  - Expect 34 symbols: 11, 01, then 30 × 10 (d = 1, s = 11 gives c0 = 1, c1 = 0), then tail 01, 11.
  - in_ready = 0 for exactly the 2 tail cycles.
- Backpressure: same stimulus as the short frame, with sym_ready toggling 1, 0, 0, 1, …
  - Symbol sequence is identical.
  - Each sym is held constant while stalled.
  - No bit is lost or duplicated.
- Back-to-back frames: two frames of bits 1 and 0, each with in_last, in_valid held high.
  - Expect 11, 10, 11, 00, 11, 10, 11, 00 (encoder returns to 00 between frames).
  - sym_last on symbols 4 and 8.
- Reset mid-frame: assert reset after the 2nd symbol of a 32-bit frame.
  - sym_valid, busy and sym_last are 0 immediately and asynchronously.
  - The next frame 1, 1 (in_last) yields 11, 01, 01, 11 with no stale state.
- Idle: in_valid = 0 for 10 cycles after reset.
  - sym_valid stays 0, in_ready stays 1, busy stays 0.
